// File: rtl/multi_prescale_counter.sv
// Multi-channel event counter: one selectable channel counts at a time, channel k
// advancing once every 2^(STEP_LOG2*k) enabled cycles, with wrap/saturate overflow.
module multi_prescale_counter #(
  parameter int WIDTH     = 64,
  parameter int CHANNELS  = 4,
  parameter int STEP_LOG2 = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [$clog2(CHANNELS)-1:0] slt,
  input  logic                        mode,
  input  logic                        clr,
  output logic [WIDTH*CHANNELS-1:0]   count,
  output logic [CHANNELS-1:0]         ovf,
  output logic                        tick
);

  localparam int SW = $clog2(CHANNELS);
  localparam int PW = (STEP_LOG2 * (CHANNELS - 1) > 0) ? STEP_LOG2 * (CHANNELS - 1) : 1;

  // Terminal prescaler value for channel k: low STEP_LOG2*k bits set.
  function automatic logic [PW-1:0] term_of(input int k);
    logic [PW-1:0] t;
    t = '0;
    for (int i = 0; i < PW; i++) begin
      if (i < STEP_LOG2 * k) t[i] = 1'b1;
    end
    return t;
  endfunction

  logic [WIDTH-1:0]    cnt_q [CHANNELS];
  logic [PW-1:0]       psc_q [CHANNELS];
  logic [CHANNELS-1:0] sel;
  logic [CHANNELS-1:0] at_term;

  // An out-of-range slt matches no channel, so nothing updates and clr is ignored.
  always_comb begin
    sel     = '0;
    at_term = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      sel[k]     = (slt == SW'(k));
      at_term[k] = (psc_q[k] == term_of(k));
    end
  end

  assign tick = rst_n & en & ~clr & (|(sel & at_term));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CHANNELS; k++) begin
        cnt_q[k] <= '0;
        psc_q[k] <= '0;
      end
      ovf <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (sel[k]) begin
          if (clr) begin
            cnt_q[k] <= '0;
            psc_q[k] <= '0;
            ovf[k]   <= 1'b0;
          end else if (en) begin
            if (at_term[k]) begin
              psc_q[k] <= '0;
              if (&cnt_q[k]) begin
                // mode 1 saturates by leaving the all-ones value in place
                ovf[k] <= 1'b1;
                if (!mode) cnt_q[k] <= '0;
              end else begin
                cnt_q[k] <= cnt_q[k] + WIDTH'(1);
              end
            end else begin
              psc_q[k] <= psc_q[k] + PW'(1);
            end
          end
        end
      end
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_pack
    assign count[k*WIDTH +: WIDTH] = cnt_q[k];
  end

endmodule

// File: tb/tb_multi_prescale_counter.sv
// Directed bench for multi_prescale_counter (8-bit, 4 channels, step 2^2) plus a
// 3-channel instance for the out-of-range select case.
module tb_multi_prescale_counter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, mode, clr;
  logic [1:0]  slt;
  logic [31:0] count;
  logic [3:0]  ovf;
  logic        tick;

  logic        en3, clr3;
  logic [1:0]  slt3;
  logic [23:0] count3;
  logic [2:0]  ovf3;
  logic        tick3;

  logic [63:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_prescale_counter #(.WIDTH(8), .CHANNELS(4), .STEP_LOG2(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .slt(slt), .mode(mode), .clr(clr),
    .count(count), .ovf(ovf), .tick(tick)
  );

  multi_prescale_counter #(.WIDTH(8), .CHANNELS(3), .STEP_LOG2(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .slt(slt3), .mode(1'b0), .clr(clr3),
    .count(count3), .ovf(ovf3), .tick(tick3)
  );

  function automatic logic [7:0] ch(input int k);
    return count[k*8 +: 8];
  endfunction

  // Scoreboard: the expectation is queued, then popped against the observed value.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    logic [63:0] e;
    exp_q.push_back(expv);
    e = exp_q.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
    end
  endtask

  // Called at a negedge: apply inputs, check combinational tick, advance one cycle.
  task automatic drive(input logic e, input logic [1:0] s, input logic c,
                       input logic m, input logic exp_tick);
    en = e; slt = s; clr = c; mode = m;
    #1;
    check("tick", {63'd0, tick}, {63'd0, exp_tick});
    @(negedge clk);
  endtask

  task automatic drive3(input logic e, input logic [1:0] s, input logic c,
                        input logic exp_tick);
    en3 = e; slt3 = s; clr3 = c;
    #1;
    check("tick3", {63'd0, tick3}, {63'd0, exp_tick});
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; slt = 2'd0; mode = 1'b0; clr = 1'b0;
    en3 = 1'b0; slt3 = 2'd0; clr3 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_tick", {63'd0, tick}, 64'd0);
    check("reset_count", {32'd0, count}, 64'd0);
    check("reset_ovf", {60'd0, ovf}, 64'd0);
    rst_n = 1'b1;

    // ch0 increments every enabled edge
    for (int i = 0; i < 10; i++) drive(1'b1, 2'd0, 1'b0, 1'b0, 1'b1);
    check("ch0_ten", {56'd0, ch(0)}, 64'd10);
    check("others_zero", {40'd0, count[31:8]}, 64'd0);

    // ch1 every 4th edge, ch2 every 16th
    for (int i = 0; i < 12; i++) drive(1'b1, 2'd1, 1'b0, 1'b0, (i % 4) == 3);
    check("ch1_three", {56'd0, ch(1)}, 64'd3);
    for (int i = 0; i < 16; i++) drive(1'b1, 2'd2, 1'b0, 1'b0, i == 15);
    check("ch2_one", {56'd0, ch(2)}, 64'd1);
    check("ch0_held", {56'd0, ch(0)}, 64'd10);

    drive(1'b0, 2'd2, 1'b0, 1'b0, 1'b0);
    check("en0_hold", {32'd0, count}, 64'h0001030a);

    // wrap then saturate on ch0
    drive(1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
    check("ch0_clr", {56'd0, ch(0)}, 64'd0);
    for (int i = 0; i < 255; i++) drive(1'b1, 2'd0, 1'b0, 1'b0, 1'b1);
    check("ch0_255", {56'd0, ch(0)}, 64'd255);
    check("ovf_none", {60'd0, ovf}, 64'd0);
    drive(1'b1, 2'd0, 1'b0, 1'b0, 1'b1);
    check("ch0_wrap", {56'd0, ch(0)}, 64'd0);
    check("ovf_wrap", {60'd0, ovf}, 64'd1);
    for (int i = 0; i < 255; i++) drive(1'b1, 2'd0, 1'b0, 1'b0, 1'b1);
    check("ovf_sticky", {60'd0, ovf}, 64'd1);
    drive(1'b1, 2'd0, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 2'd0, 1'b0, 1'b1, 1'b1);
    check("ch0_sat", {56'd0, ch(0)}, 64'd255);
    check("ovf_sat", {60'd0, ovf}, 64'd1);

    // clear beats increment and drops the overflow flag
    drive(1'b1, 2'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) drive(1'b1, 2'd0, 1'b0, 1'b0, 1'b1);
    check("ch0_seven", {56'd0, ch(0)}, 64'd7);
    drive(1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
    check("clr_count", {32'd0, count}, 64'h00010300);
    check("clr_ovf", {60'd0, ovf}, 64'd0);

    // prescaler phase survives deselection
    drive(1'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    check("ch1_clr", {56'd0, ch(1)}, 64'd0);
    drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, 2'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
    check("ch1_phase", {56'd0, ch(1)}, 64'd1);
    check("ch0_five", {56'd0, ch(0)}, 64'd5);

    // out-of-range select on the 3-channel instance
    en = 1'b0;
    for (int i = 0; i < 3; i++) drive3(1'b1, 2'd0, 1'b0, 1'b1);
    check("d3_ch0", {40'd0, count3}, 64'd3);
    drive3(1'b1, 2'd3, 1'b1, 1'b0);
    drive3(1'b1, 2'd3, 1'b0, 1'b0);
    check("d3_oor_count", {40'd0, count3}, 64'd3);
    check("d3_oor_ovf", {61'd0, ovf3}, 64'd0);
    en3 = 1'b0;

    // reset pulse between edges with ch1 prescaler at 3
    for (int i = 0; i < 3; i++) drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    check("ch1_pre_rst", {56'd0, ch(1)}, 64'd1);
    en = 1'b1; slt = 2'd1; clr = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_count", {32'd0, count}, 64'd0);
    check("rst_ovf", {60'd0, ovf}, 64'd0);
    check("rst_tick", {63'd0, tick}, 64'd0);
    check("rst_count3", {40'd0, count3}, 64'd0);
    en = 1'b0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) drive(1'b1, 2'd1, 1'b0, 1'b0, i == 3);
    check("ch1_after_rst", {56'd0, ch(1)}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
